butterfly_r4_pipe: RTL and testbench

Pipelined, parametrised radix-4 decimation-in-time butterfly for the FFT datapath. It accepts one group of four complex samples and three complex twiddles per beat and returns four complex outputs three cycles later. Handshakes are valid/ready with full backpressure. A forward/inverse mode, runtime output scaling with rounding, and saturation with a per-beat flag are supported. It sits between the twiddle ROM/address generator and the stage memory of each FFT pass.

---
 rtl/butterfly_r4_pipe_pkg.sv | 46 ++++
 rtl/butterfly_r4_pipe_if.sv | 33 +++
 rtl/butterfly_r4_pipe_cmul.sv | 36 +++
 rtl/butterfly_r4_pipe.sv | 151 +++++++++++++++
 tb/tb_butterfly_r4_pipe.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/butterfly_r4_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_pkg: shared FFT datapath defaults, component packing and scale/sat.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package fft_pkg;

    localparam int FFT_DW = 17;
    localparam int FFT_TW = 8;

    // LSB of component k (re or im) in a {.., xk_re, xk_im, ..} packed bus.
    function automatic int comp_lsb(input int k, input logic is_re, input int w);
        return (2 * k + (is_re ? 1 : 0)) * w;
    endfunction

    function automatic logic signed [31:0] scale_sat(
        input  logic signed [31:0] v,
        input  logic [1:0]         s,
        input  int                 dw,
        output logic               sat
    );
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        int                 sh;
        sh  = (s == 2'd3) ? 2 : int'(s);
        r   = v;
        if (sh > 0) begin
            r = r + (32'sd1 <<< (sh - 1));
        end
        r   = r >>> sh;
        hi  = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (dw - 1));
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/butterfly_r4_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | butterfly_r4_pipe_if: input/output beat bundle of the radix-4 butterfly.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface butterfly_r4_pipe_if
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int TW = FFT_TW
);
    logic              in_valid;
    logic              in_ready;
    logic [8*DW-1:0]   in_data;
    logic [6*TW-1:0]   tw_in;
    logic              inverse;
    logic [1:0]        scale;
    logic              out_valid;
    logic              out_ready;
    logic [8*DW-1:0]   out_data;
    logic              out_sat;

    modport master (
        output in_valid, in_data, tw_in, inverse, scale, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, tw_in, inverse, scale, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/butterfly_r4_pipe_cmul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmul_round: complex sample x twiddle product, rounded half up to DW+1.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cmul_round
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int TW = FFT_TW
) (
    input  wire logic signed [DW-1:0] xr_i,
    input  wire logic signed [DW-1:0] xi_i,
    input  wire logic signed [TW-1:0] wr_i,
    input  wire logic signed [TW-1:0] wi_i,
    output logic signed [DW:0]        re_o,
    output logic signed [DW:0]        im_o
);
    localparam int PW = DW + TW + 1;
    localparam logic signed [PW-1:0] c_half = PW'(1) <<< (TW - 3);

    logic signed [PW-1:0] w_re_rnd;
    logic signed [PW-1:0] w_im_rnd;
    logic [1:0]           w_unused_re_hi;
    logic [1:0]           w_unused_im_hi;
    logic [TW-3:0]        w_unused_re_lo;
    logic [TW-3:0]        w_unused_im_lo;

    assign w_re_rnd = PW'(xr_i) * PW'(wr_i) - PW'(xi_i) * PW'(wi_i) + c_half;
    assign w_im_rnd = PW'(xr_i) * PW'(wi_i) + PW'(xi_i) * PW'(wr_i) + c_half;

    // Slicing off the TW-2 fraction bits is the arithmetic shift; |w| <= 1 keeps the top two bits redundant.
    assign {w_unused_re_hi, re_o, w_unused_re_lo} = w_re_rnd;
    assign {w_unused_im_hi, im_o, w_unused_im_lo} = w_im_rnd;
endmodule
`default_nettype wire

// File: rtl/butterfly_r4_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | butterfly_r4_pipe: 3-stage radix-4 DIT butterfly with a global stall.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module butterfly_r4_pipe
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int TW = FFT_TW
) (
    input  wire logic          clk,
    input  wire logic          rst,
    butterfly_r4_pipe_if.slave bus
);
    localparam int AW = DW + 1;
    localparam int BW = DW + 2;
    localparam int YW = DW + 3;

    logic                 w_advance;
    logic signed [DW-1:0] w_x_re [4];
    logic signed [DW-1:0] w_x_im [4];
    logic signed [AW-1:0] a_re_d [4];
    logic signed [AW-1:0] a_im_d [4];
    logic signed [AW-1:0] a_re_q [4];
    logic signed [AW-1:0] a_im_q [4];
    logic                 s1_valid_q;
    logic                 s1_inv_q;
    logic [1:0]           s1_scale_q;
    logic signed [BW-1:0] b_re_d [4];
    logic signed [BW-1:0] b_im_d [4];
    logic signed [BW-1:0] b_re_q [4];
    logic signed [BW-1:0] b_im_q [4];
    logic                 s2_valid_q;
    logic                 s2_inv_q;
    logic [1:0]           s2_scale_q;
    logic signed [YW-1:0] w_y_re [4];
    logic signed [YW-1:0] w_y_im [4];
    logic [31-DW:0]       w_unused_hi [8];
    logic [8*DW-1:0]      out_data_d;
    logic [8*DW-1:0]      out_data_q;
    logic                 out_sat_d;
    logic                 out_sat_q;
    logic                 out_valid_q;

    assign w_advance     = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = w_advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_unpack
            assign w_x_re[k] = bus.in_data[comp_lsb(k, 1'b1, DW) +: DW];
            assign w_x_im[k] = bus.in_data[comp_lsb(k, 1'b0, DW) +: DW];
        end
        for (genvar k = 1; k < 4; k++) begin : g_cmul
            cmul_round #(.DW(DW), .TW(TW)) u_cmul (
                .xr_i (w_x_re[k]),
                .xi_i (w_x_im[k]),
                .wr_i (bus.tw_in[comp_lsb(k - 1, 1'b1, TW) +: TW]),
                .wi_i (bus.tw_in[comp_lsb(k - 1, 1'b0, TW) +: TW]),
                .re_o (a_re_d[k]),
                .im_o (a_im_d[k])
            );
        end
    endgenerate

    assign a_re_d[0] = {w_x_re[0][DW-1], w_x_re[0]};
    assign a_im_d[0] = {w_x_im[0][DW-1], w_x_im[0]};

    always_comb begin
        b_re_d[0] = BW'(a_re_q[0]) + BW'(a_re_q[2]);
        b_im_d[0] = BW'(a_im_q[0]) + BW'(a_im_q[2]);
        b_re_d[1] = BW'(a_re_q[0]) - BW'(a_re_q[2]);
        b_im_d[1] = BW'(a_im_q[0]) - BW'(a_im_q[2]);
        b_re_d[2] = BW'(a_re_q[1]) + BW'(a_re_q[3]);
        b_im_d[2] = BW'(a_im_q[1]) + BW'(a_im_q[3]);
        b_re_d[3] = BW'(a_re_q[1]) - BW'(a_re_q[3]);
        b_im_d[3] = BW'(a_im_q[1]) - BW'(a_im_q[3]);
    end

    always_comb begin
        logic signed [YW-1:0] p_re;
        logic signed [YW-1:0] p_im;
        logic signed [YW-1:0] m_re;
        logic signed [YW-1:0] m_im;
        logic                 sat_re;
        logic                 sat_im;
        sat_re    = 1'b0;
        sat_im    = 1'b0;
        // p = b1 - j*b3, m = b1 + j*b3; inverse swaps which lands on y1/y3.
        p_re      = YW'(b_re_q[1]) + YW'(b_im_q[3]);
        p_im      = YW'(b_im_q[1]) - YW'(b_re_q[3]);
        m_re      = YW'(b_re_q[1]) - YW'(b_im_q[3]);
        m_im      = YW'(b_im_q[1]) + YW'(b_re_q[3]);
        w_y_re[0] = YW'(b_re_q[0]) + YW'(b_re_q[2]);
        w_y_im[0] = YW'(b_im_q[0]) + YW'(b_im_q[2]);
        w_y_re[2] = YW'(b_re_q[0]) - YW'(b_re_q[2]);
        w_y_im[2] = YW'(b_im_q[0]) - YW'(b_im_q[2]);
        w_y_re[1] = s2_inv_q ? m_re : p_re;
        w_y_im[1] = s2_inv_q ? m_im : p_im;
        w_y_re[3] = s2_inv_q ? p_re : m_re;
        w_y_im[3] = s2_inv_q ? p_im : m_im;
        out_data_d = '0;
        out_sat_d  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_unused_hi[i] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            {w_unused_hi[2*k+1], out_data_d[comp_lsb(k, 1'b1, DW) +: DW]} =
                scale_sat(32'(w_y_re[k]), s2_scale_q, DW, sat_re);
            {w_unused_hi[2*k], out_data_d[comp_lsb(k, 1'b0, DW) +: DW]} =
                scale_sat(32'(w_y_im[k]), s2_scale_q, DW, sat_im);
            out_sat_d = out_sat_d | sat_re | sat_im;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_inv_q    <= 1'b0;
            s1_scale_q  <= '0;
            a_re_q      <= '{default: '0};
            a_im_q      <= '{default: '0};
            s2_valid_q  <= 1'b0;
            s2_inv_q    <= 1'b0;
            s2_scale_q  <= '0;
            b_re_q      <= '{default: '0};
            b_im_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (w_advance) begin
            s1_valid_q  <= bus.in_valid;
            s1_inv_q    <= bus.inverse;
            s1_scale_q  <= bus.scale;
            a_re_q      <= a_re_d;
            a_im_q      <= a_im_d;
            s2_valid_q  <= s1_valid_q;
            s2_inv_q    <= s1_inv_q;
            s2_scale_q  <= s1_scale_q;
            b_re_q      <= b_re_d;
            b_im_q      <= b_im_d;
            out_valid_q <= s2_valid_q;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_butterfly_r4_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_butterfly_r4_pipe: scoreboard bench against a DFT-style reference.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_butterfly_r4_pipe;
    localparam int DW = 17;
    localparam int TW = 8;
    localparam int XW = 8 * DW;
    localparam int WW = 6 * TW;

    typedef struct {
        logic [XW-1:0] data;
        logic          sat;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];

    butterfly_r4_pipe_if #(.DW(DW), .TW(TW)) bus ();
    butterfly_r4_pipe #(.DW(DW), .TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [XW-1:0] px(input int x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i);
        return {DW'(x3r), DW'(x3i), DW'(x2r), DW'(x2i), DW'(x1r), DW'(x1i), DW'(x0r), DW'(x0i)};
    endfunction

    function automatic logic [WW-1:0] pw(input int w1r, w1i, w2r, w2i, w3r, w3i);
        return {TW'(w3r), TW'(w3i), TW'(w2r), TW'(w2i), TW'(w1r), TW'(w1i)};
    endfunction

    // Reference: a_k = round(x_k*w_k), y_n = sum_k a_k * W^(n*k), W = -j (forward) or +j (inverse).
    function automatic void model(input logic [XW-1:0] din, input logic [WW-1:0] tw, input bit inv,
                                  input logic [1:0] sc, output logic [XW-1:0] dout, output logic sat);
        longint ar[4];
        longint ai[4];
        longint xr, xi, wr, wi, yr, yi, t, lim;
        int     sh, m;
        lim  = longint'(1) << (DW - 1);
        sh   = (sc == 2'd3) ? 2 : int'(sc);
        dout = '0;
        sat  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            xr = longint'($signed(din[(2*k+1)*DW +: DW]));
            xi = longint'($signed(din[(2*k)*DW +: DW]));
            if (k == 0) begin
                ar[k] = xr;
                ai[k] = xi;
            end else begin
                wr = longint'($signed(tw[(2*k-1)*TW +: TW]));
                wi = longint'($signed(tw[(2*k-2)*TW +: TW]));
                ar[k] = (xr * wr - xi * wi + (longint'(1) << (TW - 3))) >>> (TW - 2);
                ai[k] = (xr * wi + xi * wr + (longint'(1) << (TW - 3))) >>> (TW - 2);
            end
        end
        for (int n = 0; n < 4; n++) begin
            yr = 0;
            yi = 0;
            for (int k = 0; k < 4; k++) begin
                m = (n * k) % 4;
                if (inv) m = (4 - m) % 4;
                case (m)
                    0: begin yr = yr + ar[k]; yi = yi + ai[k]; end
                    1: begin yr = yr + ai[k]; yi = yi - ar[k]; end
                    2: begin yr = yr - ar[k]; yi = yi - ai[k]; end
                    default: begin yr = yr - ai[k]; yi = yi + ar[k]; end
                endcase
            end
            for (int c = 0; c < 2; c++) begin
                t = (c == 0) ? yr : yi;
                if (sh > 0) t = (t + (longint'(1) << (sh - 1))) >>> sh;
                if (t > lim - 1) begin t = lim - 1; sat = 1'b1; end
                if (t < -lim) begin t = -lim; sat = 1'b1; end
                dout[(2*n+1-c)*DW +: DW] = t[DW-1:0];
            end
        end
    endfunction

    // Called at a negedge; returns at the next negedge.
    task automatic drive(input bit v, input logic [XW-1:0] d, input logic [WW-1:0] tw, input bit inv,
                         input logic [1:0] sc, input bit chk, output bit acc);
        exp_t          e;
        logic [XW-1:0] ed;
        logic          es;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.tw_in    = tw;
        bus.inverse  = inv;
        bus.scale    = sc;
        #4;
        acc = v && bus.in_ready;
        if (acc) begin
            model(d, tw, inv, sc, ed, es);
            e.data    = ed;
            e.sat     = es;
            e.acc_cyc = cyc;
            e.chk_lat = chk;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic send_beat(input logic [XW-1:0] d, input logic [WW-1:0] tw, input bit inv, input logic [1:0] sc);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) drive(1'b1, d, tw, inv, sc, 1'b1, acc);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no acceptance expected acceptance");
        end
        drain();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && bus.out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h expected no beat", bus.out_data);
                end else if (bus.out_ready) begin
                    e = sb.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("out_sat", XW'(bus.out_sat), XW'(e.sat));
                    if (e.chk_lat) check("latency", XW'(cyc - e.acc_cyc), XW'(3));
                end else begin
                    check("hold_data", bus.out_data, sb[0].data);
                    check("stall_in_ready", XW'(bus.in_ready), XW'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    logic [WW-1:0] w64;

    initial begin : main
        bit            acc;
        int            got, n, w[6];
        logic [XW-1:0] d;
        logic [WW-1:0] tw;
        w64           = pw(64, 0, 64, 0, 64, 0);
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.tw_in     = '0;
        bus.inverse   = 1'b0;
        bus.scale     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        check("rst_out_valid", XW'(bus.out_valid), XW'(0));
        check("rst_out_data", bus.out_data, XW'(0));
        check("rst_out_sat", XW'(bus.out_sat), XW'(0));
        check("rst_in_ready", XW'(bus.in_ready), XW'(1));
        @(negedge clk);
        rst = 1'b0;

        send_beat(px(100, 0, 0, 0, 0, 0, 0, 0), w64, 1'b0, 2'd0);
        send_beat(px(0, 0, 10, 0, 0, 0, 0, 0), w64, 1'b0, 2'd0);
        send_beat(px(0, 0, 10, 0, 0, 0, 0, 0), w64, 1'b1, 2'd0);
        send_beat(px(0, 0, 100, 0, 0, 0, 0, 0), pw(0, 64, 64, 0, 64, 0), 1'b0, 2'd0);
        send_beat(px(0, 0, 3, 0, 0, 0, 0, 0), pw(32, 0, 64, 0, 64, 0), 1'b0, 2'd0);
        send_beat(px(0, 0, -3, 0, 0, 0, 0, 0), pw(32, 0, 64, 0, 64, 0), 1'b0, 2'd0);
        send_beat(px(65535, 0, 65535, 0, 65535, 0, 65535, 0), w64, 1'b0, 2'd0);
        send_beat(px(65535, 0, 65535, 0, 65535, 0, 65535, 0), w64, 1'b0, 2'd2);
        send_beat(px(-65536, 77, 1234, -999, 40000, -40000, -5, 6), pw(0, -64, -45, 45, 30, -20), 1'b1, 2'd3);

        got = 0;
        n   = 0;
        while (got < 20 && n < 300) begin
            bus.out_ready = !(n >= 10 && n < 15);
            for (int i = 0; i < 6; i++) w[i] = int'($urandom_range(0, 90)) - 45;
            if ($urandom_range(0, 4) == 0) begin
                w[0] = 64;
                w[1] = 0;
            end
            tw = pw(w[0], w[1], w[2], w[3], w[4], w[5]);
            d  = XW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            drive($urandom_range(0, 3) != 0, d, tw, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, acc);
            if (acc) got++;
            n++;
        end
        bus.out_ready = 1'b1;
        check("stream_beats", XW'(got), XW'(20));
        drain();

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, px(500 + i, i, 7, 0, 0, 0, 0, 0), w64, 1'b0, 2'd0, 1'b0, acc);
        end
        #2;
        check("pre_rst_valid", XW'(bus.out_valid), XW'(1));
        rst = 1'b1;
        #1;
        check("midrst_out_valid", XW'(bus.out_valid), XW'(0));
        check("midrst_out_data", bus.out_data, XW'(0));
        check("midrst_out_sat", XW'(bus.out_sat), XW'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        send_beat(px(-20, 30, 0, 0, 0, 0, 0, 0), w64, 1'b0, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
